ra_builder: RTL and testbench
=============================

Name: ra_builder

Overview:
- Writer side of the Region Array (RA) format. Builds the RA for a rectangular tile grid in VRAM, one entry per tile.
- Each entry is a control word plus one Object List (OL) pointer per primitive type. Entries are written so the RA parser can walk them unchanged.
- Sits at the end of the TA path. Fired once per frame, after list setup and before the render trigger.

Parameters:
- NUM_TYPES, 5, number of list types in order O, OM, T, TM, PT.
- EMPTY_PTR, 32'h80000000, pointer value that marks an unused list.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ra_build_trig  in  1  start pulse; ignored while busy
- FPU_PARAM_CFG  in  32  bit 21 = RA format v2 (6-word entries), else v1 (5-word entries)
- TA_ALLOC_CTRL  in  32  OPB size codes: [1:0] O, [5:4] OM, [9:8] T, [13:12] TM, [17:16] PT
- REGION_BASE  in  32  RA start address; bits [22:0] used
- TA_OL_BASE  in  32  OL area start, relative to PARAM_BASE; bits [23:0] used
- TA_GLOB_TILE_CLIP  in  32  [5:0] = tiles_x-1, [19:16] = tiles_y-1
- cfg_zclear  in  1  copied to control bit 30 of every entry
- cfg_flush  in  1  copied to control bit 28 of every entry
- ra_vram_wr  out  1  write request
- ra_vram_addr  out  24  write address
- ra_vram_dout  out  32  write data
- ra_vram_wait  in  1  stall; when high, the current write is not accepted
- ra_build_busy  out  1  high from the cycle after trig until done
- ra_build_done  out  1  one-cycle pulse when the build completes

Behaviour:
- Reset: every output is 0; state = IDLE; all internal pointers cleared.
- Register sampling: all inputs are sampled on the trig cycle and held until done.
- Per-tile OL block size, in bytes:
  - size_k = 0 when the code is 0, else 16<<code (32, 64 or 128 bytes).
  - tiles = (tx+1)*(ty+1), maximum 64*16 = 1024.
- Type bases:
  - base_0 = TA_OL_BASE[23:0].
  - base_k = base_(k-1) + tiles*size_(k-1), computed as tiles<<log2(size).
  - All arithmetic is 24-bit and wraps.
- Pointer for tile i of type k = base_k + i*size_k. It is kept as a running register per type and incremented by size_k after each tile; no multiplier.
- States:
  - IDLE: on trig → SETUP, busy=1.
  - SETUP: one cycle per type (5 cycles), computing base_k into ptr_k → CTRL.
  - CTRL: write the control word for the current tile → LIST with k=0.
  - LIST(k): write ptr_k, or EMPTY_PTR when size_k==0.
    - After k=3 in v1, or k=4 in v2 → NEXT.
    - PT is never written in v1.
  - NEXT: advance ptr_k += size_k for every type; step x, then y (raster order, x inner).
    - Last tile → DONE.
    - Otherwise → CTRL.
  - DONE: ra_build_done=1 for 1 cycle, busy=0 → IDLE.
- Control word:
  - bit 31 = last tile; bit 30 = cfg_zclear; bit 28 = cfg_flush.
  - [13:8] = tile y; [7:2] = tile x; all other bits 0.
- Address:
  - Starts at {1'b0, REGION_BASE[22:0]}.
  - Advances by 4 per accepted word, across entries with no gaps; wraps at 24 bits.
- VRAM handshake:
  - ra_vram_wr is held high, with addr and dout stable, while ra_vram_wait is high.
  - A word is accepted on a cycle with wr=1 and wait=0. The FSM advances only then.
  - With no wait, the block writes one word per cycle and the NEXT state adds 1 idle cycle per tile.
- Latency: the first wr comes 6 cycles after the trig edge (IDLE→SETUP×5→CTRL).
- Trig while busy is ignored. Input changes while busy have no effect.
- Reset mid-build: immediate return to IDLE with wr=0 and busy=0. No done pulse.

Decomposition:
- Shared package pvr_ra_pkg holds:
  - EMPTY_PTR;
  - control-bit positions (LAST=31, ZCLEAR=30, FLUSH=28, tile-y/tile-x fields);
  - TA_ALLOC_CTRL field offsets;
  - the type-order enum O/OM/T/TM/PT;
  - the opb→size function.
- This package is shared with ra_parser.
- Sub-module ra_ol_ptr_gen holds the five running pointers, base setup and per-tile increment. The top level keeps the FSM, tile counters and VRAM handshake.

Test Plan:
- 2x1 grid, v1, o_opb=1 (others 0), REGION_BASE=0x1000, OL_BASE=0x2000 → ten writes, in order:
  - 0x1000=0x00000000, 0x1004=0x00002000;
  - 0x1008, 0x100C, 0x1010 = 0x80000000;
  - 0x1014=0x80000004, 0x1018=0x00002020;
  - then three 0x80000000; then done pulse.
- 1x1 grid, v2, all opb=1 → six writes:
  - control = 0x80000000;
  - pointers 0x2000, 0x2020, 0x2040, 0x2060, 0x2080.
- cfg_zclear=1, cfg_flush=1, 1x1 grid → control word = 0xD0000000.
- 64x16 grid, v1 → exactly 5120 writes. The final control word is 0x80000FFC, and the final address is REGION_BASE+0x4FFC.
- ra_vram_wait held high for 7 cycles on the 3rd word → wr, addr and dout are stable throughout, and no word is skipped or duplicated. A trig during busy has no effect.
- reset asserted mid-build → next cycle wr=0, busy=0, and no done pulse. A fresh trig then rebuilds from REGION_BASE.

Source files
------------

// File: rtl/pvr_ra_pkg.sv
// pvr_ra_pkg: Region Array definitions shared by ra_builder and ra_parser.
// Contents: the empty-list marker, control-word bit positions, the
// TA_ALLOC_CTRL size-code layout, the list type order and the OPB size decode.
package pvr_ra_pkg;
  localparam int NUM_TYPES = 5;
  localparam logic [31:0] EMPTY_PTR = 32'h8000_0000;
  localparam int CTL_LAST = 31;
  localparam int CTL_ZCLEAR = 30;
  localparam int CTL_FLUSH = 28;
  localparam int CTL_Y_LSB = 8;
  localparam int CTL_X_LSB = 2;
  localparam int OPB_STRIDE = 4;
  localparam int CFG_V2_BIT = 21;
  typedef enum logic [2:0] {LT_O, LT_OM, LT_T, LT_TM, LT_PT} list_type_e;
  function automatic logic [23:0] opb_size(input logic [1:0] code);
    return code == 2'd0 ? 24'd0 : 24'd16 << code;
  endfunction
endpackage

// File: rtl/ra_ol_ptr_gen.sv
// ra_ol_ptr_gen: running Object List pointers, one per list type.
// Ports: opb/ol_base/tiles are the frame's latched setup; setup loads the base
// of type sel, step advances every pointer by its per-tile block size, and
// ptr_word is the RA word for type sel (EMPTY_PTR when that list is unused).
module ra_ol_ptr_gen
  import pvr_ra_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_TYPES-1:0][1:0]  opb,
  input  logic [23:0]                ol_base,
  input  logic [10:0]                tiles,
  input  logic                       setup,
  input  logic                       step,
  input  logic [2:0]                 sel,
  output logic [31:0]                ptr_word
);
  logic [NUM_TYPES-1:0][23:0] ptr;
  logic [23:0] acc, cur, blk;
  // acc carries the end of the previous type's area into the next setup cycle
  assign cur = sel == 3'd0 ? ol_base : acc;
  assign blk = opb[sel] == 2'd0 ? 24'd0 : {13'd0, tiles} << (3'd4 + {1'b0, opb[sel]});
  assign ptr_word = opb_size(opb[sel]) == 24'd0 ? EMPTY_PTR : {8'd0, ptr[sel]};
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
      acc <= '0;
    end else if (setup) begin
      ptr[sel] <= cur;
      acc <= cur + blk;
    end else if (step) begin
      for (int i = 0; i < NUM_TYPES; i++) ptr[i] <= ptr[i] + opb_size(opb[i]);
    end
  end
endmodule

// File: rtl/ra_builder.sv
// ra_builder: writes one Region Array entry per tile into VRAM.
// Ports: clock/reset; ra_build_trig starts a build, sampling all config inputs
// (FPU_PARAM_CFG, TA_ALLOC_CTRL, REGION_BASE, TA_OL_BASE, TA_GLOB_TILE_CLIP,
// cfg_zclear, cfg_flush); ra_vram_* is the stallable write port;
// ra_build_busy / ra_build_done report progress.
module ra_builder
  import pvr_ra_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ra_build_trig,
  input  logic [31:0] FPU_PARAM_CFG,
  input  logic [31:0] TA_ALLOC_CTRL,
  input  logic [31:0] REGION_BASE,
  input  logic [31:0] TA_OL_BASE,
  input  logic [31:0] TA_GLOB_TILE_CLIP,
  input  logic        cfg_zclear,
  input  logic        cfg_flush,
  output logic        ra_vram_wr,
  output logic [23:0] ra_vram_addr,
  output logic [31:0] ra_vram_dout,
  input  logic        ra_vram_wait,
  output logic        ra_build_busy,
  output logic        ra_build_done
);
  typedef enum logic [2:0] {IDLE, SETUP, CTRL, LIST, NEXT, DONE} state_e;
  state_e state, state_n;
  logic [2:0] k, k_n;
  logic [5:0] x, tx;
  logic [3:0] y, ty;
  logic v2, zclear, flush;
  logic [NUM_TYPES-1:0][1:0] opb;
  logic [23:0] ol_base, addr;
  logic [10:0] tiles;
  logic [31:0] ctrl, ptr_word;
  logic start, accept, last_x, last_tile, last_k, unused;
  assign start = state == IDLE && ra_build_trig;
  assign accept = ra_vram_wr && !ra_vram_wait;
  assign last_x = x == tx;
  assign last_tile = last_x && y == ty;
  // PT is only part of the entry in the 6-word format
  assign last_k = v2 ? k == LT_PT : k == LT_TM;
  assign tiles = ({5'd0, tx} + 11'd1) * ({7'd0, ty} + 11'd1);
  assign ctrl = 32'(last_tile) << CTL_LAST | 32'(zclear) << CTL_ZCLEAR | 32'(flush) << CTL_FLUSH
              | 32'(y) << CTL_Y_LSB | 32'(x) << CTL_X_LSB;
  assign ra_vram_wr = state == CTRL || state == LIST;
  assign ra_vram_addr = addr;
  assign ra_vram_dout = state == CTRL ? ctrl : state == LIST ? ptr_word : 32'd0;
  assign ra_build_busy = state != IDLE && state != DONE;
  assign ra_build_done = state == DONE;
  assign unused = ^{FPU_PARAM_CFG, TA_ALLOC_CTRL, REGION_BASE, TA_OL_BASE, TA_GLOB_TILE_CLIP};
  always_comb begin
    state_n = state;
    k_n = k;
    case (state)
      IDLE:  if (ra_build_trig) begin state_n = SETUP; k_n = '0; end
      SETUP: begin k_n = k == LT_PT ? 3'd0 : k + 3'd1; state_n = k == LT_PT ? CTRL : SETUP; end
      CTRL:  if (accept) begin state_n = LIST; k_n = '0; end
      LIST:  if (accept) begin k_n = k + 3'd1; state_n = last_k ? NEXT : LIST; end
      NEXT:  state_n = last_tile ? DONE : CTRL;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      x <= '0;
      y <= '0;
      tx <= '0;
      ty <= '0;
      v2 <= 1'b0;
      zclear <= 1'b0;
      flush <= 1'b0;
      opb <= '0;
      ol_base <= '0;
      addr <= '0;
    end else begin
      state <= state_n;
      k <= k_n;
      if (start) begin
        v2 <= FPU_PARAM_CFG[CFG_V2_BIT];
        tx <= TA_GLOB_TILE_CLIP[5:0];
        ty <= TA_GLOB_TILE_CLIP[19:16];
        zclear <= cfg_zclear;
        flush <= cfg_flush;
        for (int i = 0; i < NUM_TYPES; i++) opb[i] <= TA_ALLOC_CTRL[i*OPB_STRIDE +: 2];
        ol_base <= TA_OL_BASE[23:0];
        addr <= {1'b0, REGION_BASE[22:0]};
        x <= '0;
        y <= '0;
      end
      if (accept) addr <= addr + 24'd4;
      if (state == NEXT) begin
        x <= last_x ? 6'd0 : x + 6'd1;
        y <= last_x ? y + 4'd1 : y;
      end
    end
  end
  ra_ol_ptr_gen u_ptr (
    .clock    (clock),
    .reset    (reset),
    .opb      (opb),
    .ol_base  (ol_base),
    .tiles    (tiles),
    .setup    (state == SETUP),
    .step     (state == NEXT),
    .sel      (k),
    .ptr_word (ptr_word)
  );
endmodule

// File: tb/tb_ra_builder.sv
// tb_ra_builder: randomized self-checking bench for ra_builder against a tile-level RA model.
module tb_ra_builder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ra_build_trig = 1'b0;
  logic [31:0] FPU_PARAM_CFG = '0, TA_ALLOC_CTRL = '0, REGION_BASE = '0, TA_OL_BASE = '0, TA_GLOB_TILE_CLIP = '0;
  logic cfg_zclear = 1'b0, cfg_flush = 1'b0, ra_vram_wait = 1'b0;
  logic ra_vram_wr, ra_build_busy, ra_build_done;
  logic [23:0] ra_vram_addr;
  logic [31:0] ra_vram_dout;

  ra_builder dut (
    .clock(clock), .reset(reset), .ra_build_trig(ra_build_trig),
    .FPU_PARAM_CFG(FPU_PARAM_CFG), .TA_ALLOC_CTRL(TA_ALLOC_CTRL), .REGION_BASE(REGION_BASE),
    .TA_OL_BASE(TA_OL_BASE), .TA_GLOB_TILE_CLIP(TA_GLOB_TILE_CLIP),
    .cfg_zclear(cfg_zclear), .cfg_flush(cfg_flush),
    .ra_vram_wr(ra_vram_wr), .ra_vram_addr(ra_vram_addr), .ra_vram_dout(ra_vram_dout),
    .ra_vram_wait(ra_vram_wait), .ra_build_busy(ra_build_busy), .ra_build_done(ra_build_done)
  );

  always #5 clock = ~clock;

  typedef struct { logic [23:0] a; logic [31:0] d; } wrec_t;
  wrec_t cap_q[$], exp_q[$];
  wrec_t mon_w;
  int tests = 0, fails = 0, done_cnt = 0;
  int c_tx, c_ty;
  bit c_v2, c_z, c_f;
  logic [1:0] c_opb[5];
  logic [31:0] c_rb, c_olb;

  // every word the DUT will have accepted at the following rising edge
  always @(negedge clock) begin
    if (ra_vram_wr && !ra_vram_wait) begin
      mon_w.a = ra_vram_addr;
      mon_w.d = ra_vram_dout;
      cap_q.push_back(mon_w);
    end
    if (ra_build_done) done_cnt++;
  end

  task automatic set_cfg(input int tx, input int ty, input bit v2, input logic [9:0] opbs,
                         input logic [31:0] rb, input logic [31:0] olb, input bit z, input bit f);
    c_tx = tx; c_ty = ty; c_v2 = v2; c_rb = rb; c_olb = olb; c_z = z; c_f = f;
    for (int k = 0; k < 5; k++) c_opb[k] = opbs[2*k +: 2];
  endtask

  // expected RA: entries in raster order, pointers as base + tile_index * block_size
  task automatic model();
    int unsigned tiles;
    logic [23:0] sz[5];
    logic [23:0] base[5];
    logic [23:0] a;
    logic [31:0] d;
    int i;
    wrec_t w;
    exp_q.delete();
    tiles = (c_tx + 1) * (c_ty + 1);
    for (int k = 0; k < 5; k++) sz[k] = (c_opb[k] == 2'd0) ? 24'd0 : 24'(16 << c_opb[k]);
    base[0] = c_olb[23:0];
    for (int k = 1; k < 5; k++) base[k] = base[k-1] + 24'(tiles * sz[k-1]);
    a = {1'b0, c_rb[22:0]};
    for (int y = 0; y <= c_ty; y++)
      for (int x = 0; x <= c_tx; x++) begin
        i = y * (c_tx + 1) + x;
        d = (32'(y) << 8) | (32'(x) << 2);
        if (x == c_tx && y == c_ty) d[31] = 1'b1;
        if (c_z) d[30] = 1'b1;
        if (c_f) d[28] = 1'b1;
        w.a = a; w.d = d; exp_q.push_back(w); a = a + 24'd4;
        for (int k = 0; k < (c_v2 ? 5 : 4); k++) begin
          w.a = a;
          w.d = sz[k] == 24'd0 ? 32'h8000_0000 : {8'h00, 24'(base[k] + 24'(i) * sz[k])};
          exp_q.push_back(w);
          a = a + 24'd4;
        end
      end
  endtask

  task automatic drive_cfg();
    FPU_PARAM_CFG = $urandom; FPU_PARAM_CFG[21] = c_v2;
    TA_ALLOC_CTRL = $urandom;
    for (int k = 0; k < 5; k++) TA_ALLOC_CTRL[4*k +: 2] = c_opb[k];
    REGION_BASE = c_rb; TA_OL_BASE = c_olb;
    TA_GLOB_TILE_CLIP = $urandom; TA_GLOB_TILE_CLIP[5:0] = 6'(c_tx); TA_GLOB_TILE_CLIP[19:16] = 4'(c_ty);
    cfg_zclear = c_z; cfg_flush = c_f;
  endtask

  task automatic scramble();
    FPU_PARAM_CFG = $urandom; TA_ALLOC_CTRL = $urandom; REGION_BASE = $urandom;
    TA_OL_BASE = $urandom; TA_GLOB_TILE_CLIP = $urandom;
    cfg_zclear = 1'($urandom); cfg_flush = 1'($urandom);
  endtask

  // runs one build (inputs scrambled once busy) and scores every written word
  task automatic do_build(input string name, input bit rand_wait);
    int start_done, cyc;
    model();
    @(posedge clock); #1;
    cap_q.delete();
    drive_cfg();
    ra_build_trig = 1'b1;
    @(posedge clock); #1;
    ra_build_trig = 1'b0;
    scramble();
    start_done = done_cnt;
    cyc = 0;
    while (done_cnt == start_done && cyc < 20000) begin
      ra_vram_wait = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(posedge clock); #1;
      cyc++;
    end
    ra_vram_wait = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if (done_cnt != start_done + 1) begin
      fails++; $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt - start_done);
    end
    tests++;
    if (ra_build_busy !== 1'b0) begin
      fails++; $display("FAIL %s busy_after_done: got %b required 0", name, ra_build_busy);
    end
    tests++;
    if (cap_q.size() != exp_q.size()) begin
      fails++; $display("FAIL %s word_count: got %0d required %0d", name, cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      tests++;
      if (cap_q[i].a !== exp_q[i].a || cap_q[i].d !== exp_q[i].d) begin
        fails++;
        $display("FAIL %s word[%0d]: got %h=%h required %h=%h", name, i, cap_q[i].a, cap_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ra_build_trig = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests++; if (ra_vram_wr !== 1'b0) begin fails++; $display("FAIL reset_wr: got %b required 0", ra_vram_wr); end
    tests++; if (ra_vram_addr !== 24'd0) begin fails++; $display("FAIL reset_addr: got %h required 0", ra_vram_addr); end
    tests++; if (ra_vram_dout !== 32'd0) begin fails++; $display("FAIL reset_dout: got %h required 0", ra_vram_dout); end
    tests++; if (ra_build_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", ra_build_busy); end
    tests++; if (ra_build_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", ra_build_done); end
    @(posedge clock); #1;
    reset = 1'b0;
    ra_build_trig = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    tests++; if (ra_build_busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset: busy got %b required 0", ra_build_busy); end
  endtask

  task automatic test_latency();
    int n;
    int start_done;
    set_cfg(0, 0, 0, 10'h000, 32'h0000_3000, 32'h0000_4000, 0, 0);
    @(posedge clock); #1;
    drive_cfg();
    ra_build_trig = 1'b1;
    start_done = done_cnt;
    @(posedge clock); #1;
    ra_build_trig = 1'b0;
    n = 0;
    while (n < 50) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        tests++;
        if (ra_build_busy !== 1'b1) begin fails++; $display("FAIL busy_after_trig: got %b required 1", ra_build_busy); end
      end
      if (ra_vram_wr) break;
    end
    tests++;
    if (n != 6) begin fails++; $display("FAIL first_write_latency: got %0d cycles required 6", n); end
    n = 0;
    while (done_cnt == start_done && n < 100) begin @(posedge clock); n++; end
    tests++;
    if (done_cnt != start_done + 1) begin fails++; $display("FAIL latency_build_done: got %0d required 1", done_cnt - start_done); end
  endtask

  task automatic test_plan_vectors();
    logic [31:0] lit1[10];
    logic [31:0] lit2[6];
    lit1 = '{32'h0, 32'h2000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
             32'h8000_0004, 32'h2020, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    lit2 = '{32'h8000_0000, 32'h2000, 32'h2020, 32'h2040, 32'h2060, 32'h2080};
    set_cfg(1, 0, 0, 10'h001, 32'h1000, 32'h2000, 0, 0);
    do_build("grid2x1_v1", 0);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (i >= cap_q.size() || cap_q[i].d !== lit1[i] || cap_q[i].a !== 24'h1000 + 24'(4*i)) begin
        fails++; $display("FAIL grid2x1_literal[%0d]: got %0d words required word %h", i, cap_q.size(), lit1[i]);
      end
    end
    set_cfg(0, 0, 1, 10'h155, 32'h1000, 32'h2000, 0, 0);
    do_build("grid1x1_v2", 0);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (i >= cap_q.size() || cap_q[i].d !== lit2[i]) begin
        fails++; $display("FAIL grid1x1_v2_literal[%0d]: got %0d words required word %h", i, cap_q.size(), lit2[i]);
      end
    end
    set_cfg(0, 0, 0, 10'h000, 32'h1000, 32'h2000, 1, 1);
    do_build("zclear_flush", 0);
    tests++;
    if (cap_q.size() == 0 || cap_q[0].d !== 32'hD000_0000) begin
      fails++; $display("FAIL zclear_flush_ctrl: got %0d words required control d0000000", cap_q.size());
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      set_cfg($urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom), 10'($urandom),
              $urandom, $urandom, 1'($urandom), 1'($urandom));
      do_build("random", 1);
    end
  endtask

  task automatic test_full_grid();
    logic [31:0] rb;
    rb = $urandom;
    set_cfg(63, 15, 0, 10'($urandom), rb, $urandom, 0, 0);
    do_build("grid64x16", 0);
    tests++;
    if (cap_q.size() != 5120 || cap_q[5115].d !== 32'h8000_0FFC) begin
      fails++; $display("FAIL full_grid_last_ctrl: got %0d words required 5120 ending in control 80000ffc", cap_q.size());
    end
    tests++;
    if (cap_q.size() != 5120 || cap_q[5119].a !== {1'b0, rb[22:0]} + 24'h4FFC) begin
      fails++; $display("FAIL full_grid_last_addr: got %0d words required last addr %h", cap_q.size(), {1'b0, rb[22:0]} + 24'h4FFC);
    end
  endtask

  task automatic test_wait_stall();
    int cyc, start_done;
    logic [23:0] snap_a;
    logic [31:0] snap_d;
    set_cfg(1, 0, 1, 10'h2D9, 32'h0001_2340, 32'h00AB_C000, 1, 0);
    model();
    @(posedge clock); #1;
    cap_q.delete();
    drive_cfg();
    ra_build_trig = 1'b1;
    start_done = done_cnt;
    @(posedge clock); #1;
    ra_build_trig = 1'b0;
    scramble();
    cyc = 0;
    while (cap_q.size() < 2 && cyc < 100) begin @(posedge clock); #1; cyc++; end
    ra_vram_wait = 1'b1;
    @(negedge clock);
    snap_a = ra_vram_addr;
    snap_d = ra_vram_dout;
    tests++;
    if (ra_vram_wr !== 1'b1 || snap_a !== exp_q[2].a || snap_d !== exp_q[2].d) begin
      fails++; $display("FAIL stall_word: got wr=%b %h=%h required 1 %h=%h", ra_vram_wr, snap_a, snap_d, exp_q[2].a, exp_q[2].d);
    end
    ra_build_trig = 1'b1;
    repeat (6) begin
      @(negedge clock);
      ra_build_trig = 1'b0;
      tests++;
      if (ra_vram_wr !== 1'b1 || ra_vram_addr !== snap_a || ra_vram_dout !== snap_d) begin
        fails++; $display("FAIL stall_hold: got wr=%b %h=%h required 1 %h=%h", ra_vram_wr, ra_vram_addr, ra_vram_dout, snap_a, snap_d);
      end
    end
    @(posedge clock); #1;
    ra_vram_wait = 1'b0;
    cyc = 0;
    while (done_cnt == start_done && cyc < 200) begin @(posedge clock); cyc++; end
    repeat (10) @(posedge clock);
    #1;
    tests++;
    if (done_cnt != start_done + 1 || ra_build_busy !== 1'b0) begin
      fails++; $display("FAIL stall_done: got %0d pulses busy=%b required 1 pulse busy=0", done_cnt - start_done, ra_build_busy);
    end
    tests++;
    if (cap_q.size() != exp_q.size()) begin
      fails++; $display("FAIL stall_word_count: got %0d required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      tests++;
      if (cap_q[i].a !== exp_q[i].a || cap_q[i].d !== exp_q[i].d) begin
        fails++; $display("FAIL stall word[%0d]: got %h=%h required %h=%h", i, cap_q[i].a, cap_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, d0;
    set_cfg(3, 2, 1, 10'($urandom), $urandom, $urandom, 0, 1);
    @(posedge clock); #1;
    cap_q.delete();
    drive_cfg();
    ra_build_trig = 1'b1;
    @(posedge clock); #1;
    ra_build_trig = 1'b0;
    cyc = 0;
    while (cap_q.size() < 7 && cyc < 100) begin @(posedge clock); #1; cyc++; end
    reset = 1'b1;
    d0 = done_cnt;
    @(posedge clock);
    @(negedge clock);
    tests++;
    if (ra_vram_wr !== 1'b0 || ra_build_busy !== 1'b0 || ra_build_done !== 1'b0) begin
      fails++; $display("FAIL reset_mid: got wr=%b busy=%b done=%b required 0 0 0", ra_vram_wr, ra_build_busy, ra_build_done);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    tests++;
    if (done_cnt != d0 || ra_build_busy !== 1'b0) begin
      fails++; $display("FAIL reset_mid_quiet: got %0d done pulses busy=%b required 0 busy=0", done_cnt - d0, ra_build_busy);
    end
    do_build("rebuild_after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_plan_vectors();
    test_random();
    test_wait_stall();
    test_reset_mid();
    test_full_grid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
